// File: rtl/hdb3_pkg.sv
// hdb3_pkg: constants and types shared by the HDB3 receive path
// (hdb3_decoder, hdb3_violation_det) and any future encoder self-checker.
//   HDB3_DELAY       : depth of the V/B removal delay line (B00V span).
//   DEF_ZERO_RUN_MAX : default longest legal run of zero symbols.
//   POL_POS/POL_NEG  : encodings of pulse polarity (taken from the P rail).
//   pn_sym_t         : one dual-rail line symbol {p, n}.
package hdb3_pkg;

    localparam int   HDB3_DELAY       = 4;
    localparam int   DEF_ZERO_RUN_MAX = 3;
    localparam logic POL_POS          = 1'b1;
    localparam logic POL_NEG          = 1'b0;

    typedef struct packed {
        logic p;
        logic n;
    } pn_sym_t;

    // A pulse is present when exactly one rail is high.
    function automatic logic sym_mark(input pn_sym_t s);
        return s.p ^ s.n;
    endfunction

    // Both rails high is never produced by a legal encoder.
    function automatic logic sym_illegal(input pn_sym_t s);
        return s.p & s.n;
    endfunction

endpackage

// File: rtl/hdb3_violation_det.sv
// hdb3_violation_det: classifies each enabled dual-rail symbol and tracks
// the polarity of the last legal pulse so that bipolar violations (V) can
// be recognised.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_en      : symbol strobe; rails are only looked at when high
//   in_P, in_N : positive / negative pulse rails
//   mark       : legal pulse present on this enabled sample
//   is_v       : that pulse repeats the previous pulse polarity (a V)
//   illegal    : both rails high on this enabled sample
module hdb3_violation_det
    import hdb3_pkg::*;
#(
    parameter logic INIT_POL = POL_NEG
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_en,
    input  logic in_P,
    input  logic in_N,
    output logic mark,
    output logic is_v,
    output logic illegal
);

    pn_sym_t sym;
    logic    last_pol;

    assign sym     = '{p: in_P, n: in_N};
    assign mark    = in_en & sym_mark(sym);
    assign illegal = in_en & sym_illegal(sym);
    // Polarity of a legal pulse is simply which rail carries it.
    assign is_v    = mark & (in_P == last_pol);

    // Every legal pulse, including a V, becomes the reference polarity;
    // an illegal symbol leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pol <= INIT_POL;
        end else if (mark) begin
            last_pol <= in_P;
        end
    end

endmodule

// File: rtl/hdb3_decoder.sv
// hdb3_decoder: recovers NRZ data from an HDB3 dual-rail symbol stream.
// Each V pulse is removed together with the symbol three positions earlier
// (the B of B00V; already a zero for 000V), restoring the 0000 run.
// Line-code errors (both rails high, or a zero run longer than
// ZERO_RUN_MAX once a pulse has been seen) give a one-cycle code_err.
// Optional build macro HDB3_DECODER_ERRCNT_EN adds err_cnt, a saturating
// count of code_err pulses.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_en      : symbol strobe; in_P/in_N sampled only when high
//   in_P, in_N : positive / negative pulse rails
//   out_data   : recovered bit, 4 enabled samples after its symbol
//   out_valid  : out_data updated this cycle (after the line has filled)
//   code_err   : registered one-cycle line-code error pulse
//   err_cnt    : saturating error count (HDB3_DECODER_ERRCNT_EN only)
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int   ZERO_RUN_MAX = DEF_ZERO_RUN_MAX,
    parameter logic INIT_POL     = POL_NEG,
    parameter int   ERRCNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_en,
    input  logic                in_P,
    input  logic                in_N,
    output logic                out_data,
    output logic                out_valid,
    output logic                code_err
`ifdef HDB3_DECODER_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    // Zero counter has to hold ZERO_RUN_MAX+1, where it saturates.
    localparam int ZW = $clog2(ZERO_RUN_MAX + 2);
    localparam logic [ZW-1:0] ZERO_SAT = ZW'(ZERO_RUN_MAX + 1);
    localparam logic [ZW-1:0] ZERO_LIM = ZW'(ZERO_RUN_MAX);
    localparam logic [2:0]    FILL_MAX = 3'(HDB3_DELAY);

    logic                  mark;
    logic                  is_v;
    logic                  illegal;
    logic [HDB3_DELAY-1:0] dly;        // dly[0] newest .. dly[3] oldest
    logic [2:0]            fill_cnt;
    logic [ZW-1:0]         zero_cnt;
    logic                  seen_pulse;
    logic                  run_hit;
    logic                  err_now;

    hdb3_violation_det #(
        .INIT_POL (INIT_POL)
    ) u_vdet (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_en   (in_en),
        .in_P    (in_P),
        .in_N    (in_N),
        .mark    (mark),
        .is_v    (is_v),
        .illegal (illegal)
    );

    // This enabled zero (illegal symbols count as zeros) is the one that
    // takes the run past the legal limit; after that the counter sits at
    // ZERO_SAT so the run is flagged only once.
    assign run_hit = in_en & ~mark & seen_pulse & (zero_cnt == ZERO_LIM);
    assign err_now = illegal | run_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly        <= '0;
            fill_cnt   <= '0;
            zero_cnt   <= '0;
            seen_pulse <= 1'b0;
            out_data   <= 1'b0;
            out_valid  <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            if (in_en) begin
                // A V wipes itself (newest) and its B partner, which is the
                // symbol now moving from dly[2] into dly[3].
                dly[0]    <= mark & ~is_v;
                dly[1]    <= dly[0];
                dly[2]    <= dly[1];
                dly[3]    <= dly[2] & ~is_v;
                out_data  <= dly[3];
                out_valid <= (fill_cnt == FILL_MAX);
                if (fill_cnt != FILL_MAX) begin
                    fill_cnt <= fill_cnt + 3'd1;
                end
                code_err <= err_now;
                if (mark) begin
                    zero_cnt   <= '0;
                    seen_pulse <= 1'b1;
                end else if (seen_pulse && (zero_cnt != ZERO_SAT)) begin
                    zero_cnt <= zero_cnt + 1'b1;
                end
            end
        end
    end

`ifdef HDB3_DECODER_ERRCNT_EN
    // Counts in step with code_err so both show the same error together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_now && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// tb_hdb3_decoder: randomized and directed stimulus for hdb3_decoder with a
// behavioural reference model (decoded-symbol history array plus a plain
// zero-run length). Expected per-cycle responses go into exp_q; a monitor
// pops and compares one entry after every rising edge.
module tb_hdb3_decoder;

    localparam int ZMAX  = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic in_en;
    logic in_P;
    logic in_N;
    logic out_data;
    logic out_valid;
    logic code_err;
`ifdef HDB3_DECODER_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] exp_cnt_q[$];
`endif

    // {out_valid, code_err, out_data}
    logic [2:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_hist[$];     // decoded mark per enabled sample since reset
    int m_k;           // enabled samples since reset
    bit m_last_pol;
    int m_zrun;        // current zero run length (unbounded)
    bit m_seen;
    bit m_data;
    int m_errs;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    hdb3_decoder #(
        .ZERO_RUN_MAX (ZMAX),
        .INIT_POL     (1'b0),
        .ERRCNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_en     (in_en),
        .in_P      (in_P),
        .in_N      (in_N),
        .out_data  (out_data),
        .out_valid (out_valid),
        .code_err  (code_err)
`ifdef HDB3_DECODER_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic model_reset();
        m_hist.delete();
        m_k        = 0;
        m_last_pol = 1'b0;
        m_zrun     = 0;
        m_seen     = 1'b0;
        m_data     = 1'b0;
        m_errs     = 0;
    endtask

    // Hold reset low for n cycles, with random rail activity that must be ignored.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            in_en = 1'($urandom_range(0, 1));
            in_P  = 1'($urandom_range(0, 1));
            in_N  = 1'($urandom_range(0, 1));
            model_reset();
            exp_q.push_back(3'b000);
`ifdef HDB3_DECODER_ERRCNT_EN
            exp_cnt_q.push_back('0);
`endif
        end
    endtask

    // ---------------- driver + reference model ----------------
    task automatic drive(input bit en, input bit p, input bit n);
        bit mark, ill, v, valid, err;
        @(negedge clk);
        rst_n = 1'b1;
        in_en = en;
        in_P  = p;
        in_N  = n;
        valid = 1'b0;
        err   = 1'b0;
        if (en) begin
            mark = p ^ n;
            ill  = p & n;
            v    = mark && (p == m_last_pol);
            if (mark) m_last_pol = p;
            // Decoded stream: a V and the symbol three earlier become zeros.
            m_hist.push_back(mark && !v);
            if (v && m_k >= 3) m_hist[m_k-3] = 1'b0;
            // Output is the symbol four samples back; zeros while filling.
            if (m_k >= 4) begin
                valid  = 1'b1;
                m_data = m_hist[m_k-4];
            end else begin
                m_data = 1'b0;
            end
            m_k++;
            if (mark) begin
                m_seen = 1'b1;
                m_zrun = 0;
            end else if (m_seen) begin
                m_zrun++;
            end
            err = ill || (!mark && m_seen && m_zrun == ZMAX + 1);
            if (err && m_errs < (1 << CNT_W) - 1) m_errs++;
        end
        exp_q.push_back({valid, err, m_data});
`ifdef HDB3_DECODER_ERRCNT_EN
        exp_cnt_q.push_back(CNT_W'(m_errs));
`endif
    endtask

    task automatic sym(input int s);  // 0 zero, 1 positive, -1 negative, 2 illegal
        case (s)
            1:       drive(1'b1, 1'b1, 1'b0);
            -1:      drive(1'b1, 1'b0, 1'b1);
            2:       drive(1'b1, 1'b1, 1'b1);
            default: drive(1'b1, 1'b0, 1'b0);
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        logic [2:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", longint'(out_valid), longint'(e[2]));
            check("code_err", longint'(code_err), longint'(e[1]));
            check("out_data", longint'(out_data), longint'(e[0]));
`ifdef HDB3_DECODER_ERRCNT_EN
            if (exp_cnt_q.size() > 0)
                check("err_cnt", longint'(err_cnt), longint'(exp_cnt_q.pop_front()));
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        rst_n = 1'b0;
        in_en = 1'b0;
        in_P  = 1'b0;
        in_N  = 1'b0;
        model_reset();
        do_reset(2);

        // Alternating marks, no violations
        sym(1); sym(-1); sym(1); sym(-1);
        // + then 000V (V positive)
        sym(1); sym(0); sym(0); sym(0); sym(1);
        // last pulse +, then B00V with B and V negative
        sym(-1); sym(0); sym(0); sym(-1);
        // illegal symbol mid-stream
        sym(1); sym(2); sym(-1);
        // one pulse, then an over-long zero run (flag once), then more zeros
        sym(1); sym(0); sym(0); sym(0); sym(0); sym(0); sym(0);
        sym(-1); sym(0); sym(0); sym(0); sym(0);

        // idle gaps, then reset after two samples
        do_reset(1);
        sym(1); idle(3); sym(-1); idle(3);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            sym((i % 2 == 0) ? 1 : -1);
            idle(3);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                r = int'($urandom_range(0, 19));
                if (r == 0)       sym(2);
                else if (r < 9)   sym(0);
                else if (r < 14)  sym(1);
                else              sym(-1);
            end
        end
        idle(2);

        // drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
